// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_pkg
// Brief    : Shared AES constants, FSM/update encodings and GF(2^8) helpers
//            used by the encipher, decipher and key memory blocks.
// Revision : 1.0  initial release
// ============================================================================
package aes_pkg;

  localparam logic       AES_128_BIT_KEY = 1'b0;
  localparam logic       AES_256_BIT_KEY = 1'b1;
  localparam logic [3:0] AES128_ROUNDS   = 4'ha;
  localparam logic [3:0] AES256_ROUNDS   = 4'he;

  typedef enum logic [1:0] {
    CTRL_IDLE = 2'd0,
    CTRL_INIT = 2'd1,
    CTRL_SBOX = 2'd2,
    CTRL_MAIN = 2'd3
  } ctrl_state_t;

  // What the datapath does on the coming clock edge.
  typedef enum logic [2:0] {
    UPD_NONE  = 3'd0,
    UPD_START = 3'd1,
    UPD_INIT  = 3'd2,
    UPD_SBOX  = 3'd3,
    UPD_MAIN  = 3'd4,
    UPD_FINAL = 3'd5
  } update_t;

  function automatic logic [7:0] gm2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm3(input logic [7:0] b);
    return gm2(b) ^ b;
  endfunction

  // MixColumns on one column; byte [31:24] is row 0.
  function automatic logic [31:0] mixw(input logic [31:0] w);
    logic [7:0] b0, b1, b2, b3;
    b0 = w[31:24];
    b1 = w[23:16];
    b2 = w[15:8];
    b3 = w[7:0];
    return {gm2(b0) ^ gm3(b1) ^ b2      ^ b3,
            b0      ^ gm2(b1) ^ gm3(b2) ^ b3,
            b0      ^ b1      ^ gm2(b2) ^ gm3(b3),
            gm3(b0) ^ b1      ^ b2      ^ gm2(b3)};
  endfunction

  function automatic logic [127:0] mixcolumns(input logic [127:0] data);
    return {mixw(data[127:96]), mixw(data[95:64]),
            mixw(data[63:32]),  mixw(data[31:0])};
  endfunction

  // Output column i, row r takes input column (i+r) mod 4, row r.
  function automatic logic [127:0] shiftrows(input logic [127:0] data);
    logic [31:0] w0, w1, w2, w3;
    w0 = data[127:96];
    w1 = data[95:64];
    w2 = data[63:32];
    w3 = data[31:0];
    return {w0[31:24], w1[23:16], w2[15:8], w3[7:0],
            w1[31:24], w2[23:16], w3[15:8], w0[7:0],
            w2[31:24], w3[23:16], w0[15:8], w1[7:0],
            w3[31:24], w0[23:16], w1[15:8], w2[7:0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_encipher_block_if.sv
`default_nettype none
// ============================================================================
// Module   : aes_encipher_block_if
// Brief    : Start/ready handshake, data and key memory signals of the
//            AES encipher block.
// Revision : 1.0  initial release
// ============================================================================
interface aes_encipher_block_if;

  logic         next;
  logic         keylen;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic [127:0] block;
  logic [127:0] new_block;
  logic         ready;

  // Encipher side.
  modport slave (
    input  next, keylen, round_key, block,
    output round, new_block, ready
  );

  // Controller / key memory side.
  modport master (
    output next, keylen, round_key, block,
    input  round, new_block, ready
  );

endinterface
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
// Module   : aes_sbox
// Brief    : Four parallel forward AES S-box lookups (one 32-bit word).
// Revision : 1.0  initial release
// ============================================================================
module aes_sbox (
  input  wire logic [31:0] i_word,
  output logic      [31:0] o_word
);

  localparam logic [7:0] c_SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign o_word = {c_SBOX[i_word[31:24]], c_SBOX[i_word[23:16]],
                   c_SBOX[i_word[15:8]],  c_SBOX[i_word[7:0]]};

endmodule
`default_nettype wire

// File: rtl/aes_encipher_block.sv
`default_nettype none
// ============================================================================
// Module   : aes_encipher_block
// Brief    : Iterative AES-128/256 encipher round engine. One S-box is shared
//            across the four state words (four SubWord cycles per round),
//            followed by one ShiftRows/MixColumns/AddRoundKey cycle.
// Revision : 1.0  initial release
// ============================================================================
module aes_encipher_block
  import aes_pkg::*;
(
  input  wire logic           clk,
  input  wire logic           reset_n,
  aes_encipher_block_if.slave bus
);

  ctrl_state_t  r_state;
  ctrl_state_t  w_state_next;
  update_t      w_update;

  logic [31:0]  r_w [4];
  logic [3:0]   r_round_ctr;
  logic [1:0]   r_sword_ctr;
  logic         r_keylen;
  logic         r_ready;

  logic [3:0]   w_nr;
  logic [31:0]  w_sbox_in;
  logic [31:0]  w_sbox_out;
  logic [127:0] w_state;
  logic [127:0] w_shifted;
  logic [127:0] w_load_data;

  assign w_state   = {r_w[0], r_w[1], r_w[2], r_w[3]};
  assign w_nr      = (r_keylen == AES_256_BIT_KEY) ? AES256_ROUNDS : AES128_ROUNDS;
  assign w_sbox_in = r_w[r_sword_ctr];
  assign w_shifted = shiftrows(w_state);

  assign bus.round     = r_round_ctr;
  assign bus.new_block = w_state;
  assign bus.ready     = r_ready;

  aes_sbox u_sbox (
    .i_word (w_sbox_in),
    .o_word (w_sbox_out)
  );

  // Full-width value loaded into the state for INIT, MAIN and final rounds.
  always_comb begin
    w_load_data = w_shifted ^ bus.round_key;
    case (w_update)
      UPD_INIT: w_load_data = bus.block ^ bus.round_key;
      UPD_MAIN: w_load_data = mixcolumns(w_shifted) ^ bus.round_key;
      default:  w_load_data = w_shifted ^ bus.round_key;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= CTRL_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and datapath update selection.
  always_comb begin
    w_state_next = r_state;
    w_update     = UPD_NONE;
    case (r_state)
      CTRL_IDLE: begin
        if (bus.next) begin
          w_update     = UPD_START;
          w_state_next = CTRL_INIT;
        end
      end
      CTRL_INIT: begin
        w_update     = UPD_INIT;
        w_state_next = CTRL_SBOX;
      end
      CTRL_SBOX: begin
        w_update = UPD_SBOX;
        if (r_sword_ctr == 2'd3) begin
          w_state_next = CTRL_MAIN;
        end
      end
      CTRL_MAIN: begin
        if (r_round_ctr == w_nr) begin
          w_update     = UPD_FINAL;
          w_state_next = CTRL_IDLE;
        end else begin
          w_update     = UPD_MAIN;
          w_state_next = CTRL_SBOX;
        end
      end
      default: begin
        w_state_next = CTRL_IDLE;
      end
    endcase
  end

  // State word registers: full-width loads or one S-boxed word per cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        r_w[i] <= '0;
      end
    end else begin
      case (w_update)
        UPD_INIT, UPD_MAIN, UPD_FINAL: begin
          r_w[0] <= w_load_data[127:96];
          r_w[1] <= w_load_data[95:64];
          r_w[2] <= w_load_data[63:32];
          r_w[3] <= w_load_data[31:0];
        end
        UPD_SBOX: begin
          r_w[r_sword_ctr] <= w_sbox_out;
        end
        default: begin
        end
      endcase
    end
  end

  // Round/word counters, latched key length and ready flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_round_ctr <= '0;
      r_sword_ctr <= '0;
      r_keylen    <= AES_128_BIT_KEY;
      r_ready     <= 1'b1;
    end else begin
      case (w_update)
        UPD_START: begin
          r_round_ctr <= '0;
          r_keylen    <= bus.keylen;
          r_ready     <= 1'b0;
        end
        UPD_INIT: begin
          r_round_ctr <= 4'd1;
          r_sword_ctr <= '0;
        end
        UPD_SBOX: begin
          r_sword_ctr <= r_sword_ctr + 2'd1;
        end
        UPD_MAIN: begin
          r_round_ctr <= r_round_ctr + 4'd1;
          r_sword_ctr <= '0;
        end
        UPD_FINAL: begin
          r_ready <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_encipher_block.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_encipher_block
// Brief    : Self-checking bench for aes_encipher_block: FIPS-197 vectors,
//            random plaintexts against a byte-array AES model, start-pulse
//            and reset robustness.
// Revision : 1.0  initial release
// ============================================================================
module tb_aes_encipher_block;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  logic [7:0]   m_sbox  [256];
  logic [7:0]   m_isbox [256];
  logic [127:0] rk      [16];

  aes_encipher_block_if bus ();

  aes_encipher_block dut (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  // Key memory: round key looked up combinationally from the round output.
  assign bus.round_key = rk[bus.round];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xt(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // S-box from the definition: multiplicative inverse then affine transform.
  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      m_sbox[x]  = s;
      m_isbox[s] = 8'(x);
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {m_sbox[w[31:24]], m_sbox[w[23:16]], m_sbox[w[15:8]], m_sbox[w[7:0]]};
  endfunction

  // Standard key expansion; a 128-bit key occupies key[255:128].
  task automatic set_key(input logic [255:0] key, input logic kl);
    logic [31:0] w [60];
    logic [31:0] tmp;
    logic [7:0]  rc;
    int nk, nr;
    nk = kl ? 8 : 4;
    nr = kl ? 14 : 10;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = xt(rc);
      end else if (nk == 8 && i % nk == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int r = 0; r < 16; r++) rk[r] = '0;
    for (int r = 0; r <= nr; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Byte i of the block is column i/4, row i%4.
  function automatic logic [127:0] model_enc(input logic [127:0] pt, input int nr);
    logic [127:0] st;
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] u [16];
    st = pt ^ rk[0];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) s[i] = st[127 - 8*i -: 8];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          t[4*c+row] = m_sbox[s[4*((c+row)%4)+row]];
      for (int c = 0; c < 4; c++) begin
        if (r != nr) begin
          u[4*c+0] = gmul(8'h02, t[4*c]) ^ gmul(8'h03, t[4*c+1]) ^ t[4*c+2] ^ t[4*c+3];
          u[4*c+1] = t[4*c] ^ gmul(8'h02, t[4*c+1]) ^ gmul(8'h03, t[4*c+2]) ^ t[4*c+3];
          u[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(8'h02, t[4*c+2]) ^ gmul(8'h03, t[4*c+3]);
          u[4*c+3] = gmul(8'h03, t[4*c]) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(8'h02, t[4*c+3]);
        end else begin
          for (int row = 0; row < 4; row++) u[4*c+row] = t[4*c+row];
        end
      end
      for (int i = 0; i < 16; i++) st[127 - 8*i -: 8] = u[i];
      st = st ^ rk[r];
    end
    return st;
  endfunction

  function automatic logic [127:0] model_dec(input logic [127:0] ct, input int nr);
    logic [127:0] st;
    logic [7:0] s [16];
    logic [7:0] t [16];
    st = ct ^ rk[nr];
    for (int r = nr; r >= 1; r--) begin
      for (int i = 0; i < 16; i++) s[i] = st[127 - 8*i -: 8];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          t[4*c+row] = m_isbox[s[4*((c+4-row)%4)+row]];
      for (int i = 0; i < 16; i++) st[127 - 8*i -: 8] = t[i];
      st = st ^ rk[r-1];
      if (r - 1 > 0) begin
        for (int i = 0; i < 16; i++) s[i] = st[127 - 8*i -: 8];
        for (int c = 0; c < 4; c++) begin
          t[4*c+0] = gmul(8'h0e, s[4*c]) ^ gmul(8'h0b, s[4*c+1]) ^ gmul(8'h0d, s[4*c+2]) ^ gmul(8'h09, s[4*c+3]);
          t[4*c+1] = gmul(8'h09, s[4*c]) ^ gmul(8'h0e, s[4*c+1]) ^ gmul(8'h0b, s[4*c+2]) ^ gmul(8'h0d, s[4*c+3]);
          t[4*c+2] = gmul(8'h0d, s[4*c]) ^ gmul(8'h09, s[4*c+1]) ^ gmul(8'h0e, s[4*c+2]) ^ gmul(8'h0b, s[4*c+3]);
          t[4*c+3] = gmul(8'h0b, s[4*c]) ^ gmul(8'h0d, s[4*c+1]) ^ gmul(8'h09, s[4*c+2]) ^ gmul(8'h0e, s[4*c+3]);
        end
        for (int i = 0; i < 16; i++) st[127 - 8*i -: 8] = t[i];
      end
    end
    return st;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One operation, entered on a negedge with ready high. edges = number of
  // rising edges after the start edge until ready is seen (0 on timeout).
  task automatic run_op(input logic [127:0] pt, input logic kl, input int next_at,
                        input int kl_at, input bit chk_round,
                        output logic [127:0] ct, output int edges);
    bit done;
    bit round_ok;
    int nr;
    nr       = kl ? 14 : 10;
    done     = 1'b0;
    round_ok = 1'b1;
    edges    = 0;
    bus.block  = pt;
    bus.keylen = kl;
    bus.next   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.next = 1'b0;
    chk("ready_low_after_start", 128'(bus.ready), 128'(1'b0));
    if (bus.round !== 4'd0) round_ok = 1'b0;
    for (int e = 1; e <= 200 && !done; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e == 1) bus.block = rnd128();
      bus.next = (e == next_at);
      if (e == kl_at) bus.keylen = ~bus.keylen;
      if (bus.ready) begin
        done  = 1'b1;
        edges = e;
      end else if (bus.round !== 4'((e - 1) / 5 + 1)) begin
        round_ok = 1'b0;
      end
    end
    bus.next = 1'b0;
    ct = bus.new_block;
    if (chk_round) begin
      chk("round_sequence", 128'(round_ok), 128'(1'b1));
      chk("round_at_done", 128'(bus.round), 128'(nr));
    end
  endtask

  localparam logic [255:0] KEY_B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

  initial begin
    logic [127:0] ct;
    logic [127:0] pt;
    logic [255:0] key;
    int edges;
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b0;
    bus.next   = 1'b0;
    bus.keylen = 1'b0;
    bus.block  = '0;
    build_sbox();
    set_key(KEY_B, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", 128'(bus.ready), 128'(1'b1));
    chk("reset_new_block", bus.new_block, 128'h0);
    chk("reset_round", 128'(bus.round), 128'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // FIPS-197 App. B
    run_op(PT_B, 1'b0, -1, -1, 1'b0, ct, edges);
    chk("appB_ct", ct, CT_B);
    chk("appB_latency", 128'(edges), 128'(51));
    repeat (3) @(negedge clk);
    chk("appB_hold_idle", bus.new_block, CT_B);

    // FIPS-197 C.1 with round sequence
    set_key(KEY_C1, 1'b0);
    run_op(PT_C, 1'b0, -1, -1, 1'b1, ct, edges);
    chk("c1_ct", ct, CT_C1);
    chk("c1_latency", 128'(edges), 128'(51));

    // FIPS-197 C.3, keylen toggled mid-run
    set_key(KEY_C3, 1'b1);
    run_op(PT_C, 1'b1, -1, 30, 1'b1, ct, edges);
    chk("c3_ct", ct, CT_C3);
    chk("c3_latency", 128'(edges), 128'(71));

    // Start pulse during an operation is ignored
    set_key(KEY_B, 1'b0);
    run_op(PT_B, 1'b0, 20, -1, 1'b0, ct, edges);
    chk("next_ignored_ct", ct, CT_B);
    chk("next_ignored_latency", 128'(edges), 128'(51));

    // Random keys/plaintexts, both key lengths, checked and round-tripped
    for (int kl = 0; kl < 2; kl++) begin
      for (int n = 0; n < 3; n++) begin
        key = {rnd128(), rnd128()};
        pt  = rnd128();
        set_key(key, kl[0]);
        run_op(pt, kl[0], -1, -1, 1'b0, ct, edges);
        chk("random_ct", ct, model_enc(pt, kl[0] ? 14 : 10));
        chk("random_roundtrip", model_dec(ct, kl[0] ? 14 : 10), pt);
      end
    end

    // Reset in the middle of an operation
    set_key(KEY_B, 1'b0);
    bus.block  = PT_B;
    bus.keylen = 1'b0;
    bus.next   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.next = 1'b0;
    repeat (29) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_ready", 128'(bus.ready), 128'(1'b1));
    chk("midreset_new_block", bus.new_block, 128'h0);
    chk("midreset_round", 128'(bus.round), 128'h0);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(PT_B, 1'b0, -1, -1, 1'b0, ct, edges);
    chk("after_reset_ct", ct, CT_B);
    chk("after_reset_latency", 128'(edges), 128'(51));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
